// File: rtl/note_energy_accum.sv
// Per-note energy accumulator: sums FFT bin magnitudes per note over a frame,
// then scans all notes for the strongest averaged energy and reports it.
module note_energy_accum #(
  parameter int MAG_W  = 16,
  parameter int ACC_W  = 18,
  parameter int THRESH = 512
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [MAG_W-1:0] i_mag,
  input  logic [4:0]       i_note_idx,
  input  logic [1:0]       i_note_avg,
  output logic             o_busy,
  output logic             o_valid,
  output logic [4:0]       o_note,
  output logic [MAG_W-1:0] o_note_mag
);

  localparam int unsigned NOTES   = 25;
  localparam logic [4:0]  LAST_K  = 5'd24;
  localparam logic [4:0]  NO_NOTE = 5'd25;
  localparam int          PROD_W  = ACC_W + 8;
  localparam int          CW      = (ACC_W > MAG_W) ? ACC_W : MAG_W;
  localparam logic [MAG_W-1:0] THR     = MAG_W'(THRESH);
  localparam logic [CW-1:0]    MAG_MAX = CW'({MAG_W{1'b1}});

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, OUT} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc [NOTES];
  logic [1:0]       avg [NOTES];
  logic [4:0]       scan_idx;
  logic [4:0]       best_idx;
  logic [MAG_W-1:0] best_mag;

  // Sample path: saturating add into the addressed note.
  logic             hit;
  logic [4:0]       idx_c;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_sum;

  always_comb begin
    hit     = (i_note_idx <= LAST_K);
    idx_c   = hit ? i_note_idx : '0;
    sum     = {1'b0, acc[idx_c]} + (ACC_W+1)'(i_mag);
    sat_sum = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  // Scan path: average of the note under scan, clamped to the output width.
  // Divide-by-3 uses the reciprocal 171/512 in a widened product.
  logic [ACC_W-1:0]  acc_k;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  raw;
  logic [CW-1:0]     raw_w;
  logic [MAG_W-1:0]  avg_val;

  always_comb begin
    acc_k = acc[scan_idx];
    prod  = PROD_W'(acc_k) * PROD_W'(171);
    case (avg[scan_idx])
      2'd1:    raw = acc_k;
      2'd2:    raw = acc_k >> 1;
      2'd3:    raw = ACC_W'(prod >> 9);
      default: raw = '0;
    endcase
    raw_w   = CW'(raw);
    avg_val = (raw_w > MAG_MAX) ? '1 : MAG_W'(raw_w);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      for (int unsigned i = 0; i < NOTES; i++) begin
        acc[i] <= '0;
        avg[i] <= '0;
      end
      scan_idx   <= '0;
      best_idx   <= '0;
      best_mag   <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_note     <= NO_NOTE;
      o_note_mag <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (i_valid) begin
            if (hit) begin
              acc[idx_c] <= sat_sum;
              avg[idx_c] <= i_note_avg;
            end
            if (i_last) begin
              state    <= SCAN;
              o_busy   <= 1'b1;
              scan_idx <= '0;
              best_idx <= '0;
              best_mag <= '0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (avg_val > best_mag) begin
            best_mag <= avg_val;
            best_idx <= scan_idx;
          end
          if (scan_idx == LAST_K) state <= OUT;
          else                    scan_idx <= scan_idx + 5'd1;
        end
        OUT: begin
          o_note     <= (best_mag >= THR) ? best_idx : NO_NOTE;
          o_note_mag <= best_mag;
          o_valid    <= 1'b1;
          o_busy     <= 1'b0;
          for (int unsigned i = 0; i < NOTES; i++) begin
            acc[i] <= '0;
            avg[i] <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_energy_accum.sv
// Randomized and directed check of note_energy_accum against a per-note
// arithmetic reference model of frame energy, averaging and peak picking.
module tb_note_energy_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        last;
  logic [15:0] mag;
  logic [4:0]  note_idx;
  logic [1:0]  note_avg;
  logic        busy;
  logic        out_valid;
  logic [4:0]  note;
  logic [15:0] note_mag;

  int total = 0;
  int bad   = 0;

  int macc [25];
  int mavg [25];

  note_energy_accum #(.MAG_W(16), .ACC_W(18), .THRESH(512)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .i_last     (last),
    .i_mag      (mag),
    .i_note_idx (note_idx),
    .i_note_avg (note_avg),
    .o_busy     (busy),
    .o_valid    (out_valid),
    .o_note     (note),
    .o_note_mag (note_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 25; i++) begin
      macc[i] = 0;
      mavg[i] = 0;
    end
  endtask

  function automatic void model_result(output int enote, output int emag);
    int best = 0;
    int bidx = 0;
    for (int k = 0; k < 25; k++) begin
      int a;
      if (mavg[k] == 0)      a = 0;
      else if (mavg[k] == 1) a = macc[k];
      else if (mavg[k] == 2) a = macc[k] / 2;
      else                   a = (macc[k] * 171) / 512;
      if (a > 65535) a = 65535;
      if (a > best) begin
        best = a;
        bidx = k;
      end
    end
    emag  = best;
    enote = (best >= 512) ? bidx : 25;
  endfunction

  // One input cycle while the block is accepting samples.
  task automatic send(input bit v, input bit l, input int m, input int idx, input int av);
    @(negedge clk);
    valid    = v;
    last     = l;
    mag      = 16'(m);
    note_idx = 5'(idx);
    note_avg = 2'(av);
    if (v && idx <= 24) begin
      macc[idx] = macc[idx] + m;
      if (macc[idx] > 262143) macc[idx] = 262143;
      mavg[idx] = av;
    end
  endtask

  // Cycles T+1..T+28 after an accepted i_last; junk driven while busy.
  task automatic finish_frame(input int enote, input int emag);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      chk("busy_high", int'(busy), 1);
      chk("no_valid_in_busy", int'(out_valid), 0);
      valid    = 1'($urandom_range(0, 1));
      last     = 1'($urandom_range(0, 1));
      mag      = (c == 5) ? 16'd9000 : 16'($urandom_range(0, 65535));
      note_idx = (c == 5) ? 5'd7 : 5'($urandom_range(0, 26));
      note_avg = 2'($urandom_range(1, 3));
    end
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    chk("busy_low", int'(busy), 0);
    chk("valid_pulse", int'(out_valid), 1);
    chk("note", int'(note), enote);
    chk("note_mag", int'(note_mag), emag);
    @(negedge clk);
    chk("valid_one_cycle", int'(out_valid), 0);
    chk("note_hold", int'(note), enote);
    chk("mag_hold", int'(note_mag), emag);
    model_clear();
  endtask

  task automatic finish_model();
    int en, em;
    model_result(en, em);
    finish_frame(en, em);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    mag = '0; note_idx = '0; note_avg = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_note", int'(note), 25);
    chk("rst_mag", int'(note_mag), 0);
    rst = 1'b0;

    // Directed cases
    send(1, 1, 1000, 3, 1);
    finish_frame(3, 1000);

    for (int i = 0; i < 3; i++) send(1, i == 2, 300, 16, 3);
    finish_frame(25, 300);

    send(1, 0, 600, 5, 1);
    send(1, 1, 600, 9, 1);
    finish_frame(5, 600);

    send(1, 0, 60000, 26, 1);
    send(1, 0, 60000, 25, 1);
    send(1, 1, 700, 0, 1);
    finish_frame(0, 700);

    for (int i = 0; i < 5; i++) send(1, i == 4, 65535, 12, 2);
    finish_frame(12, 65535);

    send(1, 1, 800, 4, 1);
    finish_frame(4, 800);

    // Zero-magnitude sample still sets the averaging count
    send(1, 0, 1200, 8, 1);
    send(1, 1, 0, 8, 2);
    finish_frame(8, 600);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(1, 12);
      for (int s = 0; s < n; s++) begin
        int idx, m;
        if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, 26);
        else begin
          case ($urandom_range(0, 2))
            0:       idx = 2;
            1:       idx = 11;
            default: idx = 20;
          endcase
        end
        m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 2000);
        if ($urandom_range(0, 4) == 0) send(0, 1, m, idx, 1);
        send(1, s == n - 1, m, idx, $urandom_range(1, 3));
      end
      finish_model();
    end

    // Reset in the middle of SCAN aborts the frame
    send(1, 1, 900, 7, 1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
      chk("pre_rst_busy", int'(busy), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("abort_busy", int'(busy), 0);
    chk("abort_note", int'(note), 25);
    chk("abort_mag", int'(note_mag), 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("abort_no_valid", int'(out_valid), 0);
    end

    // Accumulators were cleared by the reset
    send(1, 1, 550, 21, 1);
    finish_frame(21, 550);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
